// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and sequencing controller for a 5-stage (F/D/E/M/W) pipeline.
//   - stall/flush controls for the four pipeline registers
//   - E-stage ALU operand forwarding selects (M has priority over W)
//   - pipeline freeze while a multi-cycle data-memory access in M is pending
//   - saturating stall-cycle performance counter
//
// Optional build macro: HAZ_MEM_TIMEOUT_EN
//   Defined   : a wait counter bounds MEM_WAIT to TIMEOUT_CYC cycles. On expiry
//               the FSM returns to RUN and err_timeout sets (sticky until reset).
//   Undefined : MEM_WAIT persists until mem_ack_M; err_timeout is tied 0.
//
// Ports
//   i_clk                 clock, rising edge
//   i_rst                 synchronous reset, active low
//   rs1_addr_D/rs2_addr_D source registers of the instruction in D
//   rs1_addr_E/rs2_addr_E source registers of the instruction in E
//   rd_addr_E/M/W         destination registers in E, M, W
//   rd_wren_E/M/W         register write enables in E, M, W
//   wb_sel_E              write-back select in E (WB_MEM_CODE marks a load)
//   mispred_E             branch/jump in E mispredicted
//   mem_req_M/mem_ack_M   data-memory request (level) / completion in M
//   stall_F/D/E/M         hold PC / IF-ID / ID-EX / EX-MEM
//   flush_D/E/W           bubble into IF-ID / ID-EX / MEM-WB
//   fwd_a_sel/fwd_b_sel   00 regfile, 01 from W, 10 from M
//   stall_cnt             saturating count of cycles with stall_F=1
//   err_timeout           sticky memory timeout flag
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter logic [1:0] WB_MEM_CODE = 2'b01,
    parameter int         CNT_W       = 32,
    parameter int         TIMEOUT_CYC = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       rs1_addr_D,
    input  logic [4:0]       rs2_addr_D,
    input  logic [4:0]       rs1_addr_E,
    input  logic [4:0]       rs2_addr_E,
    input  logic [4:0]       rd_addr_E,
    input  logic [4:0]       rd_addr_M,
    input  logic [4:0]       rd_addr_W,
    input  logic             rd_wren_E,
    input  logic             rd_wren_M,
    input  logic             rd_wren_W,
    input  logic [1:0]       wb_sel_E,
    input  logic             mispred_E,
    input  logic             mem_req_M,
    input  logic             mem_ack_M,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err_timeout
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             freeze;
    logic             load_use;
    logic             timeout_hit;

    // ---------------------------------------------------------------------
    // Forwarding: one identical selector per E-stage operand.
    // ---------------------------------------------------------------------
    logic [1:0][4:0] rs_e;
    logic [1:0][1:0] fwd_raw;

    assign rs_e = {rs2_addr_E, rs1_addr_E};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            // x0 is hardwired zero, so a write to it is never forwarded.
            assign fwd_raw[gi] =
                (rd_wren_M && (rd_addr_M != 5'd0) && (rd_addr_M == rs_e[gi])) ? 2'b10 :
                (rd_wren_W && (rd_addr_W != 5'd0) && (rd_addr_W == rs_e[gi])) ? 2'b01 :
                                                                               2'b00;
        end
    endgenerate

    assign load_use = (wb_sel_E == WB_MEM_CODE) && rd_wren_E && (rd_addr_E != 5'd0) &&
                      ((rd_addr_E == rs1_addr_D) || (rd_addr_E == rs2_addr_D));

    // Freeze drops in the ack (or timeout) cycle itself so the pipeline
    // advances with no extra bubble after the memory completes.
    assign freeze = ((state_reg == MEM_WAIT) && !mem_ack_M && !timeout_hit) ||
                    ((state_reg == RUN) && mem_req_M && !mem_ack_M);

`ifdef HAZ_MEM_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              err_timeout_reg;

    assign timeout_hit = (state_reg == MEM_WAIT) && !mem_ack_M &&
                         (wait_cnt_reg == WAIT_W'(TIMEOUT_CYC - 1));

    // Held at zero while in RUN so it starts from 0 on MEM_WAIT entry.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wait_cnt_reg    <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            if (state_reg == RUN)
                wait_cnt_reg <= '0;
            else
                wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
            if (timeout_hit)
                err_timeout_reg <= 1'b1;
        end
    end

    assign err_timeout = err_timeout_reg;
`else
    // TIMEOUT_CYC has no effect in this build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timeout_hit        = 1'b0;
    assign err_timeout        = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM state register and stall counter
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_reg     <= RUN;
            stall_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (stall_F && !(&stall_cnt_reg))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;

    // ---------------------------------------------------------------------
    // Next state and pipeline controls. Priority: reset, freeze,
    // mispredict, load-use.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        stall_E    = 1'b0;
        stall_M    = 1'b0;
        flush_D    = 1'b0;
        flush_E    = 1'b0;
        flush_W    = 1'b0;
        fwd_a_sel  = 2'b00;
        fwd_b_sel  = 2'b00;

        case (state_reg)
            RUN:      if (mem_req_M && !mem_ack_M) state_next = MEM_WAIT;
            MEM_WAIT: if (mem_ack_M || timeout_hit) state_next = RUN;
            default:  state_next = RUN;
        endcase

        if (!i_rst) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
            flush_W = 1'b1;
        end else begin
            fwd_a_sel = fwd_raw[0];
            fwd_b_sel = fwd_raw[1];
            if (freeze) begin
                // Hold F..M; M keeps retrying so W must see a bubble.
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                flush_W = 1'b1;
            end else if (mispred_E) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (load_use) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int TB_TO   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             i_clk;
    logic             i_rst;
    logic [4:0]       rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E;
    logic [4:0]       rd_addr_E, rd_addr_M, rd_addr_W;
    logic             rd_wren_E, rd_wren_M, rd_wren_W;
    logic [1:0]       wb_sel_E;
    logic             mispred_E, mem_req_M, mem_ack_M;
    logic             stall_F, stall_D, stall_E, stall_M;
    logic             flush_D, flush_E, flush_W;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic             err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_wait;
    int m_cnt;
    bit m_err;
    int m_wcnt;

    hazard_ctrl #(
        .WB_MEM_CODE (2'b01),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TB_TO)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .rs1_addr_D  (rs1_addr_D),
        .rs2_addr_D  (rs2_addr_D),
        .rs1_addr_E  (rs1_addr_E),
        .rs2_addr_E  (rs2_addr_E),
        .rd_addr_E   (rd_addr_E),
        .rd_addr_M   (rd_addr_M),
        .rd_addr_W   (rd_addr_W),
        .rd_wren_E   (rd_wren_E),
        .rd_wren_M   (rd_wren_M),
        .rd_wren_W   (rd_wren_W),
        .wb_sel_E    (wb_sel_E),
        .mispred_E   (mispred_E),
        .mem_req_M   (mem_req_M),
        .mem_ack_M   (mem_ack_M),
        .stall_F     (stall_F),
        .stall_D     (stall_D),
        .stall_E     (stall_E),
        .stall_M     (stall_M),
        .flush_D     (flush_D),
        .flush_E     (flush_E),
        .flush_W     (flush_W),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall_cnt   (stall_cnt),
        .err_timeout (err_timeout)
    );

    // {stall_F,D,E,M, flush_D,E,W}
    logic [6:0]  ctl;
    logic [10:0] dut_out;
    assign ctl     = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};
    assign dut_out = {ctl, fwd_a_sel, fwd_b_sel};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rd_wren_M && rd_addr_M != 0 && rd_addr_M == rs) return 2'b10;
        if (rd_wren_W && rd_addr_W != 0 && rd_addr_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_timeout();
`ifdef HAZ_MEM_TIMEOUT_EN
        return m_wait && !mem_ack_M && (m_wcnt == TB_TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [10:0] ref_out();
        bit frozen, lu;
        logic [3:0] fw;
        if (!i_rst) return 11'b0000_111_0000;
        fw     = {ref_fwd(rs1_addr_E), ref_fwd(rs2_addr_E)};
        frozen = m_wait ? (!mem_ack_M && !ref_timeout()) : (mem_req_M && !mem_ack_M);
        lu     = (wb_sel_E == 2'b01) && rd_wren_E && (rd_addr_E != 0) &&
                 (rd_addr_E == rs1_addr_D || rd_addr_E == rs2_addr_D);
        if (frozen)    return {7'b1111_001, fw};
        if (mispred_E) return {7'b0000_110, fw};
        if (lu)        return {7'b1100_010, fw};
        return {7'b0, fw};
    endfunction

    task automatic model_step();
        logic [10:0] o;
        bit to;
        o  = ref_out();
        to = ref_timeout();
        if (!i_rst) begin
            m_wait = 0; m_cnt = 0; m_err = 0; m_wcnt = 0;
        end else begin
            if (o[10] && m_cnt < CNT_MAX) m_cnt++;
            if (!m_wait) begin
                m_wait = mem_req_M && !mem_ack_M;
                m_wcnt = 0;
            end else if (mem_ack_M) begin
                m_wait = 0;
            end else if (to) begin
                m_wait = 0;
                m_err  = 1;
            end else begin
                m_wcnt++;
            end
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_idle();
        rs1_addr_D = 0; rs2_addr_D = 0; rs1_addr_E = 0; rs2_addr_E = 0;
        rd_addr_E = 0; rd_addr_M = 0; rd_addr_W = 0;
        rd_wren_E = 0; rd_wren_M = 0; rd_wren_W = 0;
        wb_sel_E = 0; mispred_E = 0; mem_req_M = 0; mem_ack_M = 0;
    endtask

    task automatic do_reset();
        set_idle();
        i_rst = 0;
        tick();
        i_rst = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        i_rst = 0; mispred_E = 1; mem_req_M = 1;
        rd_wren_M = 1; rd_addr_M = 3; rs1_addr_E = 3;
        @(negedge i_clk);
        n_checks++;
        if (dut_out !== 11'b0000_111_0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", dut_out, 11'b0000_111_0000);
        end
        tick();
        i_rst = 1; set_idle();
        @(negedge i_clk);
        n_checks++;
        if (stall_cnt !== 0 || err_timeout !== 0 || dut_out !== 0) begin
            n_fail++;
            $display("FAIL reset_state: got cnt=%0d err=%b out=%b want 0 0 0", stall_cnt, err_timeout, dut_out);
        end
        $display("test_reset done");
    endtask

    task automatic test_forwarding();
        do_reset();
        rd_addr_M = 5; rd_wren_M = 1; rd_addr_W = 5; rd_wren_W = 1;
        rs1_addr_E = 5; rs2_addr_E = 0;
        @(negedge i_clk);
        n_checks++;
        if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_m_priority: got a=%b b=%b want a=10 b=00", fwd_a_sel, fwd_b_sel);
        end
        tick();
        rd_wren_M = 0; rs2_addr_E = 5;
        @(negedge i_clk);
        n_checks++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_from_w: got a=%b b=%b want a=01 b=01", fwd_a_sel, fwd_b_sel);
        end
        tick();
        rd_wren_M = 1; rd_addr_M = 0; rd_addr_W = 0; rs1_addr_E = 0; rs2_addr_E = 0;
        @(negedge i_clk);
        n_checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_x0: got a=%b b=%b want a=00 b=00", fwd_a_sel, fwd_b_sel);
        end
        tick();
        $display("test_forwarding done");
    endtask

    task automatic test_load_use();
        do_reset();
        wb_sel_E = 2'b01; rd_wren_E = 1; rd_addr_E = 7; rs2_addr_D = 7; rs1_addr_D = 2;
        @(negedge i_clk);
        n_checks++;
        if (ctl !== 7'b1100_010) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b want %b", ctl, 7'b1100_010);
        end
        tick();
        set_idle();
        @(negedge i_clk);
        n_checks++;
        if (stall_cnt !== 1 || ctl !== 0) begin
            n_fail++;
            $display("FAIL load_use_one_cycle: got cnt=%0d ctl=%b want cnt=1 ctl=0", stall_cnt, ctl);
        end
        wb_sel_E = 2'b01; rd_wren_E = 1; rd_addr_E = 0; rs1_addr_D = 0; rs2_addr_D = 0;
        #1;
        n_checks++;
        if (ctl !== 0) begin
            n_fail++;
            $display("FAIL load_use_x0: got %b want 0", ctl);
        end
        tick();
        @(negedge i_clk);
        n_checks++;
        if (stall_cnt !== 1) begin
            n_fail++;
            $display("FAIL load_use_x0_cnt: got %0d want 1", stall_cnt);
        end
        $display("test_load_use done");
    endtask

    task automatic test_mispredict();
        do_reset();
        wb_sel_E = 2'b01; rd_wren_E = 1; rd_addr_E = 9; rs1_addr_D = 9; mispred_E = 1;
        @(negedge i_clk);
        n_checks++;
        if (ctl !== 7'b0000_110) begin
            n_fail++;
            $display("FAIL mispred_over_lu: got %b want %b", ctl, 7'b0000_110);
        end
        tick();
        mem_req_M = 1;
        @(negedge i_clk);
        n_checks++;
        if (stall_cnt !== 0 || ctl !== 7'b1111_001) begin
            n_fail++;
            $display("FAIL mispred_frozen: got cnt=%0d ctl=%b want cnt=0 ctl=1111001", stall_cnt, ctl);
        end
        tick();
        mem_ack_M = 1;
        tick();
        $display("test_mispredict done");
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req_M = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            n_checks++;
            if (ctl !== 7'b1111_001) begin
                n_fail++;
                $display("FAIL mem_freeze_c%0d: got %b want 1111001", c, ctl);
            end
            tick();
        end
        mem_ack_M = 1;
        @(negedge i_clk);
        n_checks++;
        if (ctl !== 0) begin
            n_fail++;
            $display("FAIL mem_ack_release: got %b want 0", ctl);
        end
        tick();
        mem_ack_M = 1; mem_req_M = 1;
        @(negedge i_clk);
        n_checks++;
        if (stall_cnt !== 3 || ctl !== 0) begin
            n_fail++;
            $display("FAIL mem_hit: got cnt=%0d ctl=%b want cnt=3 ctl=0", stall_cnt, ctl);
        end
        tick();
        set_idle();
        @(negedge i_clk);
        n_checks++;
        if (stall_cnt !== 3 || ctl !== 0) begin
            n_fail++;
            $display("FAIL mem_hit_no_wait: got cnt=%0d ctl=%b want cnt=3 ctl=0", stall_cnt, ctl);
        end
        $display("test_mem_wait done");
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        mem_req_M = 1;
        tick();
        tick();
        i_rst = 0;
        @(negedge i_clk);
        n_checks++;
        if (ctl !== 7'b0000_111) begin
            n_fail++;
            $display("FAIL rst_in_wait_forced: got %b want 0000111", ctl);
        end
        tick();
        i_rst = 1; mem_req_M = 0; mem_ack_M = 1;
        @(negedge i_clk);
        n_checks++;
        if (stall_cnt !== 0 || ctl !== 0) begin
            n_fail++;
            $display("FAIL rst_in_wait_run: got cnt=%0d ctl=%b want cnt=0 ctl=0", stall_cnt, ctl);
        end
        tick();
        mem_ack_M = 0;
        @(negedge i_clk);
        n_checks++;
        if (stall_cnt !== 0 || ctl !== 0) begin
            n_fail++;
            $display("FAIL stray_ack: got cnt=%0d ctl=%b want cnt=0 ctl=0", stall_cnt, ctl);
        end
        $display("test_reset_in_wait done");
    endtask

`ifdef HAZ_MEM_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        mem_req_M = 1;
        for (int c = 0; c < TB_TO; c++) begin
            @(negedge i_clk);
            n_checks++;
            if (stall_F !== 1'b1 || err_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_freeze_c%0d: got stall_F=%b err=%b want 1 0", c, stall_F, err_timeout);
            end
            tick();
        end
        @(negedge i_clk);
        n_checks++;
        if (stall_F !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_release: got stall_F=%b want 0", stall_F);
        end
        tick();
        mem_req_M = 0;
        tick();
        tick();
        @(negedge i_clk);
        n_checks++;
        if (err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got %b want 1", err_timeout);
        end
        do_reset();
        @(negedge i_clk);
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got %b want 0", err_timeout);
        end
        $display("test_timeout done");
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            logic [10:0] exp_o;
            i_rst      = ($urandom_range(0, 24) != 0);
            rs1_addr_D = 5'($urandom_range(0, 3));
            rs2_addr_D = 5'($urandom_range(0, 3));
            rs1_addr_E = 5'($urandom_range(0, 3));
            rs2_addr_E = 5'($urandom_range(0, 3));
            rd_addr_E  = 5'($urandom_range(0, 3));
            rd_addr_M  = 5'($urandom_range(0, 3));
            rd_addr_W  = 5'($urandom_range(0, 3));
            rd_wren_E  = 1'($urandom_range(0, 1));
            rd_wren_M  = 1'($urandom_range(0, 1));
            rd_wren_W  = 1'($urandom_range(0, 1));
            wb_sel_E   = 2'($urandom_range(0, 3));
            mispred_E  = ($urandom_range(0, 3) == 0);
            mem_req_M  = ($urandom_range(0, 2) == 0);
            mem_ack_M  = ($urandom_range(0, 2) == 0);
            @(negedge i_clk);
            exp_o = ref_out();
            $display("rand %0d rst=%b req=%b ack=%b mis=%b out=%b cnt=%0d",
                     c, i_rst, mem_req_M, mem_ack_M, mispred_E, dut_out, stall_cnt);
            n_checks++;
            if (dut_out !== exp_o || stall_cnt !== CNT_W'(m_cnt) || err_timeout !== m_err) begin
                n_fail++;
                $display("FAIL rand_c%0d: got out=%b cnt=%0d err=%b want out=%b cnt=%0d err=%b",
                         c, dut_out, stall_cnt, err_timeout, exp_o, m_cnt, m_err);
            end
            tick();
        end
        $display("test_random done");
    endtask

    initial begin
        m_wait = 0; m_cnt = 0; m_err = 0; m_wcnt = 0;
        set_idle();
        i_rst = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mispredict();
        test_mem_wait();
        test_reset_in_wait();
`ifdef HAZ_MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
